// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the 8N1 UART transmitter and its write FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Bits on the wire per frame: start + data + stop.
    function automatic int frame_bits(input int stop_bits);
        return 1 + DATA_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO; bit time is baud_div+1 clocks, latched per frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        en,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [7:0]                  wdata,
    input  logic                        wr,
    output logic                        wr_ready,
    output logic                        overflow,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output uart_state_t                 dbg_state
);

    localparam int   FRAME_BITS = frame_bits(STOP_BITS);
    // Index of the final stop bit within the frame tail.
    localparam logic STOP_LAST  = 1'(FRAME_BITS - DATA_BITS - 2);

    uart_state_t      r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_stop_idx;
    logic             r_tx;
    logic             r_busy;
    logic             r_tx_done;
    logic             r_overflow;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_start;
    logic       w_bit_end;
    logic [7:0] w_rdata;

    assign w_push    = wr && !w_full;
    assign w_bit_end = (r_cnt == '0);

    // A new frame starts from IDLE, or straight out of the last stop bit so frames stay contiguous.
    always_comb begin
        w_start = 1'b0;
        if (en && !w_empty) begin
            if (r_state == IDLE) begin
                w_start = 1'b1;
            end else if (r_state == STOP && w_bit_end && r_stop_idx == STOP_LAST) begin
                w_start = 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (w_push),
        .pop   (w_start),
        .wdata (wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tx_done  <= 1'b0;
            r_overflow <= wr && w_full;
            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_cnt     <= r_div;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= r_div;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_tx_done <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                            r_cnt      <= r_div;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            // Frame load overrides the IDLE/STOP exits above; the divisor is frozen here for the whole frame.
            if (w_start) begin
                r_shift <= w_rdata;
                r_div   <= baud_div;
                r_cnt   <= baud_div;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= START;
            end
        end
    end

    assign wr_ready  = !w_full;
    assign overflow  = r_overflow;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign tx_done   = r_tx_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo: bytes are queued on acceptance and a line monitor checks every frame cycle.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int SB    = 1;
    localparam int DW    = 16;

    logic          HCLK     = 1'b0;
    logic          HRESETn  = 1'b0;
    logic          en       = 1'b0;
    logic [DW-1:0] baud_div = 16'd15;
    logic [7:0]    wdata    = 8'h00;
    logic          wr       = 1'b0;
    logic          wr_ready;
    logic          overflow;
    logic          tx;
    logic          busy;
    logic          tx_done;
    logic [2:0]    level;
    uart_state_t   dbg_state;

    int            total   = 0;
    int            bad     = 0;
    logic [7:0]    exp_q[$];
    int            mdl_cnt = 0;
    logic [DW-1:0] div_at_edge = '0;

    uart_tx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (SB),
        .DIV_W      (DW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .en        (en),
        .baud_div  (baud_div),
        .wdata     (wdata),
        .wr        (wr),
        .wr_ready  (wr_ready),
        .overflow  (overflow),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .level     (level),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 HCLK = ~HCLK;

    // Divisor value presented at the most recent rising edge.
    always @(posedge HCLK) div_at_edge <= baud_div;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line monitor / scoreboard ----------------
    task automatic check_frame();
        logic [7:0]  b;
        logic [11:0] bits;
        int          d;
        d = int'(div_at_edge);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected act=start_bit exp=idle_line t=%0t", $time);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        for (int k = 0; k < 9 + SB; k++) begin
            for (int c = 0; c <= d; c++) begin
                if (!(k == 0 && c == 0)) begin
                    @(negedge HCLK);
                    if (!HRESETn) return;
                    chk("frame_tx_done_low", tx_done, 1'b0);
                end
                chk("frame_tx_bit", tx, bits[k]);
                chk("frame_busy", busy, 1'b1);
            end
        end
        @(negedge HCLK);
        if (!HRESETn) return;
        chk("tx_done_pulse", tx_done, 1'b1);
    endtask

    initial begin
        forever begin
            @(negedge HCLK);
            while (HRESETn && tx === 1'b0) check_frame();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    // Called at a negedge; the write is presented across the next rising edge.
    task automatic write_byte(input logic [7:0] b);
        bit acc;
        acc   = (mdl_cnt < DEPTH);
        wr    = 1'b1;
        wdata = b;
        @(negedge HCLK);
        wr = 1'b0;
        if (acc) begin
            exp_q.push_back(b);
            mdl_cnt++;
        end
        chk("overflow_on_write", overflow, !acc);
    endtask

    task automatic drain(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            tick(1);
            if (exp_q.size() == 0 && !busy && level == 3'd0) done = 1'b1;
        end
        chk("drain_complete", done, 1'b1);
        tick(2);
        mdl_cnt = 0;
    endtask

    task automatic wait_not_busy(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            tick(1);
            if (!busy) done = 1'b1;
        end
        chk("wait_not_busy", done, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int lvl;
        bit all_high;

        // Reset held with write strobes toggling.
        HRESETn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            wr    = i[0];
            wdata = 8'($urandom);
            chk("rst_tx", tx, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_level", level, 3'd0);
            chk("rst_wr_ready", wr_ready, 1'b1);
            chk("rst_overflow", overflow, 1'b0);
            chk("rst_tx_done", tx_done, 1'b0);
            chk("rst_state", dbg_state, IDLE);
        end
        wr = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick(2);

        // Single byte, start-bit latency.
        en       = 1'b1;
        baud_div = 16'd15;
        write_byte(8'h55);
        chk("latency_pre_edge", tx, 1'b1);
        tick(1);
        chk("latency_start_bit", tx, 1'b0);
        drain(400);

        // Burst into a full FIFO, then contiguous transmission.
        en = 1'b0;
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        write_byte(8'h44);
        chk("burst_level_full", level, 3'd4);
        chk("burst_wr_ready", wr_ready, 1'b0);
        write_byte(8'h45);
        tick(1);
        chk("overflow_one_cycle", overflow, 1'b0);
        chk("burst_level_after_drop", level, 3'd4);
        en = 1'b1;
        for (int i = 0; i < 10 && !busy; i++) tick(1);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick(1);
        end
        chk("burst_busy_cycles", n, 640);
        drain(400);

        // Divisor extremes, divisor change mid-frame, push+pop at level 1.
        baud_div = 16'd0;
        write_byte(8'hA3);
        write_byte(8'h5C);
        chk("push_pop_level", level, 3'd1);
        baud_div = 16'd3;
        drain(400);

        // Full FIFO with a same-edge pop: the write is still dropped.
        en       = 1'b0;
        baud_div = 16'd2;
        for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
        en = 1'b1;
        write_byte(8'hEE);
        chk("full_pop_level", level, 3'd3);
        drain(1000);

        // en dropped during bit 3 of the first frame.
        en       = 1'b0;
        baud_div = 16'd3;
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        en = 1'b1;
        tick(18);
        en = 1'b0;
        wait_not_busy(200);
        chk("en_drop_level", level, 3'd1);
        all_high = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) all_high = 1'b0;
        end
        chk("en_drop_hold_idle", all_high, 1'b1);
        chk("en_drop_state", dbg_state, IDLE);
        en = 1'b1;
        drain(400);

        // Randomized rounds: fill with en low, then release at a random divisor.
        for (int r = 0; r < 8; r++) begin
            en       = 1'b0;
            baud_div = DW'($urandom_range(0, 6));
            n        = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) write_byte(8'($urandom));
            lvl = (n < DEPTH) ? n : DEPTH;
            chk("rand_level", level, lvl);
            chk("rand_wr_ready", wr_ready, lvl < DEPTH);
            en = 1'b1;
            drain(3000);
        end

        // Asynchronous reset during DATA.
        en       = 1'b1;
        baud_div = 16'd3;
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        tick(8);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_level", level, 3'd0);
        chk("async_rst_wr_ready", wr_ready, 1'b1);
        exp_q.delete();
        mdl_cnt = 0;
        all_high = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (tx_done !== 1'b0 || tx !== 1'b1) all_high = 1'b0;
        end
        HRESETn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx_done !== 1'b0 || tx !== 1'b1) all_high = 1'b0;
        end
        chk("async_rst_no_done", all_high, 1'b1);
        chk("async_rst_state", dbg_state, IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synthesizable 8N1 UART transmitter with a small write FIFO. It is the driving end of the serial link that the SoC-side receivers and the bench terminal sample.
- Used as a stimulus source on the RsRx_* pins in the SoC bench.
- Reusable as a host-side transmitter in FPGA bring-up.
- Bit timing is run-time programmable; the default matches the 16-clock (160 ns at 100 MHz) bit time used in the bench.

Parameters:
FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2
STOP_BITS, 1, stop bits per frame; 1 or 2
DIV_W, 16, width of the baud divisor input

Ports:
HCLK  input  1  system clock, rising-edge active
HRESETn  input  1  asynchronous active-low reset
en  input  1  transmit enable; gates the start of new frames only
baud_div  input  DIV_W  bit period minus one, in HCLK cycles
wdata  input  8  byte to enqueue
wr  input  1  write strobe
wr_ready  output  1  FIFO not full
overflow  output  1  one-cycle pulse when wr is asserted while full
tx  output  1  serial line, idle high; registered
busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse at the end of the last stop bit
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, HRESETn=0): tx=1, busy=0, tx_done=0, overflow=0, level=0, wr_ready=1, state=IDLE. The FIFO is emptied and any frame in flight is abandoned immediately.
- FIFO:
  - A write is accepted on an HCLK edge when wr=1 and the FIFO is not full.
  - When wr=1 and the FIFO is full, the data is dropped and overflow pulses for one cycle.
  - A simultaneous write and pop is legal in any non-full state, and level is unchanged.
  - When the FIFO is full, a same-cycle pop does not make room for the write: the write is dropped and overflow pulses.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame format: start bit 0, then 8 data bits LSB first, then STOP_BITS stop bits of 1. Each bit lasts exactly baud_div+1 cycles; baud_div=0 is legal and gives 1 cycle per bit.
- baud_div is latched at frame start. Changing it mid-frame affects the next frame only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on an edge where en=1 and level>0. On that edge the head byte is popped into the shift register, tx<=0 and busy<=1.
  - START -> DATA after baud_div+1 cycles. tx<=bit0.
  - DATA -> DATA shifts once per bit period. The bit index counts 0..7. After bit 7: STOP, tx<=1.
  - STOP -> IDLE, or directly START, after STOP_BITS*(baud_div+1) cycles. tx_done pulses on this edge.
  - The direct STOP -> START case applies when en=1 and level>0. It pops the next byte on the same edge, so back-to-back frames are contiguous with no extra idle cycle.
- Latency: for a write accepted at edge E into an empty FIFO with en=1 and IDLE, tx falls at edge E+1. One frame occupies exactly (9+STOP_BITS)*(baud_div+1) cycles.
- en deasserted mid-frame: the current frame completes normally, then the FSM holds in IDLE. The FIFO keeps accepting writes.
- busy=1 from the edge that enters START until the edge that leaves STOP without starting a new frame.
- Counters: the bit-period down-counter is DIV_W wide and the bit index is 3 bits. No arithmetic overflow is possible because the counter reloads from the latched divisor.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - DATA_BITS=8
  - frame-length helper constant (9+STOP_BITS)
- Sub-module sync_fifo: parameterized width/depth with push/pop/full/empty/level. It reports full and empty only; dropping a write while full and raising overflow is done in uart_tx_fifo, not in sync_fifo. The FSM, divisor latch, shift register and output registers stay in uart_tx_fifo.

Test Plan:
- Reset check: hold HRESETn=0 with wr toggling -> tx=1, busy=0, level=0, wr_ready=1, overflow=0 throughout.
- Single byte: baud_div=15, en=1, write 0x55 -> tx low one edge after the write. Bits are 0,1,0,1,0,1,0,1,0,1, each 160 ns, and the bench terminal prints 'U'. tx_done pulses once after 1600 ns.
- Burst/full: en=0, write 0x41,0x42,0x43,0x44 -> level=4, wr_ready=0. A 5th write 0x45 pulses overflow and is lost. Then en=1 -> "ABCD" is sent as four contiguous 160-cycle frames with no idle gap, and busy stays high throughout.
- Divisor extremes: baud_div=0, write 0xA3 -> 10-cycle frame with bits 0,1,1,0,0,0,1,0,1,1. Changing baud_div to 3 mid-frame leaves that frame at 1 cycle per bit, and the next frame runs at 4 cycles per bit.
- en drop: two bytes queued, deassert en during bit 3 of the first frame -> the first frame completes, tx stays 1, and level=1 until en returns.
- Reset mid-frame: assert HRESETn=0 during DATA -> tx=1 asynchronously, FIFO empty, and no tx_done pulse.
